artemis_mcb_port_master: RTL
============================

Name: artemis_mcb_port_master

Overview:
- User-side master for one Spartan-6 MCB user port (cmd/wr/rd FIFO triple) exported by the Artemis DDR3 infrastructure.
- Turns a single request (address, word count, read or write) into a sequence of MCB bursts of at most MAX_BURST 32-bit words.
- Moves write data from a valid/ready stream into the port write FIFO, and moves read data from the port read FIFO to a valid/ready stream.
- Sits between a Nysa memory/DMA client and one pN_* port; the pN_*_clk inputs are tied to clk outside this block.

Parameters:
- MAX_BURST, 64, maximum words per MCB command; legal range 1..64.
- COUNT_WIDTH, 24, width of req_count in 32-bit words.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- calibration_done  in  1  DDR3 calibrated; no MCB command is issued while low.
- req_stb  in  1  request strobe; accepted when req_ready=1.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1=write, 0=read.
- req_addr  in  30  starting byte address; bits [1:0] ignored and treated as 0.
- req_count  in  COUNT_WIDTH  number of words.
- done  out  1  one-cycle pulse at request completion.
- error  out  1  sticky error flag.
- wdata  in  32  write stream data.
- wdata_valid  in  1  write stream valid.
- wdata_ready  out  1  write stream ready.
- rdata  out  32  read stream data.
- rdata_valid  out  1  read stream valid.
- rdata_ready  in  1  read stream ready.
- cmd_en  out  1  MCB command push.
- cmd_instr  out  3  MCB instruction: 000 write, 001 read.
- cmd_bl  out  6  MCB burst length minus 1.
- cmd_byte_addr  out  30  MCB command byte address.
- cmd_full  in  1  MCB command FIFO full.
- cmd_empty  in  1  MCB command FIFO empty.
- wr_en  out  1  MCB write FIFO push.
- wr_mask  out  4  MCB byte mask; always 0.
- wr_data  out  32  MCB write data.
- wr_full  in  1  MCB write FIFO full.
- wr_count  in  7  MCB write FIFO count.
- wr_underrun  in  1  MCB write underrun.
- wr_error  in  1  MCB write error.
- rd_en  out  1  MCB read FIFO pop.
- rd_data  in  32  MCB read data.
- rd_empty  in  1  MCB read FIFO empty.
- rd_count  in  7  MCB read FIFO count.
- rd_overflow  in  1  MCB read overflow.
- rd_error  in  1  MCB read error.

Behaviour:
- Reset values: all outputs 0 (req_ready, done, error, cmd_en, wr_en, rd_en, cmd_instr, cmd_bl, cmd_byte_addr, rdata_valid, wdata_ready); state=IDLE; registers cleared. Reset is honoured mid-transfer; partially issued MCB traffic is abandoned and MCB FIFO contents are the integrator's problem.
- Registered state: addr (30b), remaining (COUNT_WIDTH), burst n (7b).
- n = min(remaining, MAX_BURST), latched at each burst start.
- IDLE:
  - req_ready=1.
  - On req_stb: latch req_addr with [1:0]=0, latch req_count, clear error.
  - If count=0: go to DONE with no MCB traffic.
  - Else: go to WR_FILL if req_write, otherwise RD_CMD.
- WR_FILL:
  - wdata_ready = !wr_full; wr_en = wdata_valid & !wr_full; wr_data = wdata (combinational pass-through).
  - Count pushed words; after the n-th push, go to WR_CMD.
- WR_CMD:
  - cmd_en=1 for exactly one cycle when calibration_done & !cmd_full; instr 000, bl=n-1, addr=addr.
  - Then addr += 4*n (mod 2^30, wraps silently) and remaining -= n.
  - Go to DONE if remaining=0, else WR_FILL.
- RD_CMD:
  - Same issue rule as WR_CMD with instr 001.
  - Then go to RD_DRAIN.
- RD_DRAIN:
  - rdata = rd_data; rdata_valid = !rd_empty; rd_en = !rd_empty & rdata_ready (MCB read FIFO is first-word-fall-through).
  - After n pops: update addr and remaining as above; go to DONE or RD_CMD.
- DONE: done=1 for one cycle; go to IDLE. req_stb in DONE is ignored.
- cmd_en, cmd_instr, cmd_bl and cmd_byte_addr are registered outputs, so a command appears one cycle after its issue condition.
- Only one command is outstanding at a time: there is no read prefetch and no write overlap.
- error sets on wr_underrun | wr_error | rd_overflow | rd_error in any non-IDLE state. It does not abort the transfer and holds until the next accepted request.
- calibration_done low stalls only the CMD states; WR_FILL may still fill the write FIFO.

Optional Feature:
- Macro: ARTEMIS_MCB_PORT_PERF_EN.
- Defined:
  - Adds output perf_cycles[31:0], the cycle count from request accept to the done pulse, inclusive.
  - Saturates at 0xFFFFFFFF.
  - Updated at done; reset to 0.
  - Adds output perf_stall[31:0], counting cycles spent in a CMD state with cmd_full or !calibration_done.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package artemis_mcb_pkg:
  - MCB_INSTR_WRITE=3'b000, MCB_INSTR_READ=3'b001.
  - MCB_MAX_BL=64.
  - State enum (IDLE, WR_FILL, WR_CMD, RD_CMD, RD_DRAIN, DONE).
- Sub-module artemis_mcb_burst_sizer: combinational min(remaining, MAX_BURST) plus next address and next remaining. Shared later with a DMA reader.

Test Plan:
- Write 10 words at 0x100, calibration_done=1:
  - 10 wr_en pushes, then one cmd_en with instr=000, bl=9, addr=0x100.
  - done pulses once; error=0.
- Write 150 words at 0x0, MAX_BURST=64:
  - Commands bl=63@0x000, bl=63@0x100, bl=21@0x200.
  - Exactly 150 wr_en total.
- Read 3 words at 0x40 with rdata_ready toggling every cycle and model data 0xA0,0xA1,0xA2:
  - cmd instr=001, bl=2, addr=0x40.
  - rdata beats 0xA0,0xA1,0xA2 only on ready cycles; done after the third pop.
- req_count=0: done two cycles after req_stb; no cmd_en, wr_en or rd_en ever.
- cmd_full held 5 cycles, then calibration_done low 5 cycles, during a write: cmd_en is delayed exactly until both clear and is issued once.
- Pulse rd_overflow mid-read: error=1, read still completes; next accepted request clears error.
- Assert rst mid-WR_FILL: all outputs 0 immediately; req_ready=1 on the first clock after release.

Source files
------------

// File: rtl/artemis_mcb_pkg.sv
// Shared types and constants for the Artemis MCB user-port master and its helpers.
// Spartan-6 MCB instruction encodings, burst limits and the port-master state set.
package artemis_mcb_pkg;

   localparam logic [2:0] MCB_INSTR_WRITE = 3'b000;
   localparam logic [2:0] MCB_INSTR_READ  = 3'b001;
   localparam int         MCB_MAX_BL      = 64;

   typedef enum logic [2:0] {
      IDLE,
      WR_FILL,
      WR_CMD,
      RD_CMD,
      RD_DRAIN,
      DONE
   } mcb_state_t;

   // Words in the next burst: the smaller of what is left and the burst cap.
   function automatic logic [6:0] burst_words(input logic [31:0] remaining,
                                              input int unsigned max_burst);
      logic [31:0] max_w;
      max_w = max_burst;
      return (remaining < max_w) ? remaining[6:0] : max_w[6:0];
   endfunction

endpackage

// File: rtl/artemis_mcb_burst_sizer.sv
// Combinational burst sizing: words in the current burst plus the address and
// word count left over once that burst has been moved. Also reused by the DMA reader.
module artemis_mcb_burst_sizer #(
   parameter int MAX_BURST   = 64,
   parameter int COUNT_WIDTH = 24
) (
   input  logic [COUNT_WIDTH-1:0] remaining,
   input  logic [29:0]            addr,
   output logic [6:0]             burst_n,
   output logic [29:0]            next_addr,
   output logic [COUNT_WIDTH-1:0] next_remaining
);
   import artemis_mcb_pkg::*;

   // Address arithmetic is 30 bits wide, so running off the top wraps to zero.
   always_comb begin
      burst_n        = burst_words(32'(remaining), MAX_BURST);
      next_addr      = addr + {21'd0, burst_n, 2'b00};
      next_remaining = remaining - COUNT_WIDTH'(burst_n);
   end

endmodule

// File: rtl/artemis_mcb_port_master.sv
// Single-port Spartan-6 MCB master: splits one read/write request into bursts.
// Optional perf counters are built when ARTEMIS_MCB_PORT_PERF_EN is defined.
module artemis_mcb_port_master #(
   parameter int MAX_BURST   = 64,
   parameter int COUNT_WIDTH = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   calibration_done,
   input  logic                   req_stb,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [29:0]            req_addr,
   input  logic [COUNT_WIDTH-1:0] req_count,
   output logic                   done,
   output logic                   error,
   input  logic [31:0]            wdata,
   input  logic                   wdata_valid,
   output logic                   wdata_ready,
   output logic [31:0]            rdata,
   output logic                   rdata_valid,
   input  logic                   rdata_ready,
   output logic                   cmd_en,
   output logic [2:0]             cmd_instr,
   output logic [5:0]             cmd_bl,
   output logic [29:0]            cmd_byte_addr,
   input  logic                   cmd_full,
   input  logic                   cmd_empty,
   output logic                   wr_en,
   output logic [3:0]             wr_mask,
   output logic [31:0]            wr_data,
   input  logic                   wr_full,
   input  logic [6:0]             wr_count,
   input  logic                   wr_underrun,
   input  logic                   wr_error,
   output logic                   rd_en,
   input  logic [31:0]            rd_data,
   input  logic                   rd_empty,
   input  logic [6:0]             rd_count,
   input  logic                   rd_overflow,
   input  logic                   rd_error
`ifdef ARTEMIS_MCB_PORT_PERF_EN
   ,
   output logic [31:0]            perf_cycles,
   output logic [31:0]            perf_stall
`endif
);
   import artemis_mcb_pkg::*;

   mcb_state_t             state;
   logic [29:0]            addr;
   logic [COUNT_WIDTH-1:0] remaining;
   logic [6:0]             n;
   logic [6:0]             beat;

   logic                   cmd_go;
   logic                   mcb_fault;
   logic [COUNT_WIDTH-1:0] size_rem;
   logic [6:0]             size_n;
   logic [29:0]            size_next_addr;
   logic [COUNT_WIDTH-1:0] size_next_rem;
   logic                   unused_inputs;

   assign unused_inputs = ^{cmd_empty, wr_count, rd_count};

   assign cmd_go    = calibration_done & ~cmd_full;
   assign mcb_fault = wr_underrun | wr_error | rd_overflow | rd_error;
   assign wr_data   = wdata;
   assign wr_mask   = 4'b0000;
   assign rdata     = rd_data;

   // In IDLE the sizer looks at the incoming request so the first burst size is ready at accept.
   assign size_rem = (state == IDLE) ? req_count : remaining;

   artemis_mcb_burst_sizer #(
      .MAX_BURST  (MAX_BURST),
      .COUNT_WIDTH(COUNT_WIDTH)
   ) u_sizer (
      .remaining     (size_rem),
      .addr          (addr),
      .burst_n       (size_n),
      .next_addr     (size_next_addr),
      .next_remaining(size_next_rem)
   );

   // Stream handshakes pass straight through; the MCB read FIFO is first-word-fall-through.
   always_comb begin
      wdata_ready = 1'b0;
      wr_en       = 1'b0;
      rdata_valid = 1'b0;
      rd_en       = 1'b0;
      if (state == WR_FILL) begin
         wdata_ready = ~wr_full;
         wr_en       = wdata_valid & ~wr_full;
      end
      if (state == RD_DRAIN) begin
         rdata_valid = ~rd_empty;
         rd_en       = ~rd_empty & rdata_ready;
      end
   end

   // Request sequencer: one MCB command in flight at a time, all command outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         addr          <= '0;
         remaining     <= '0;
         n             <= '0;
         beat          <= '0;
         req_ready     <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         cmd_en        <= 1'b0;
         cmd_instr     <= '0;
         cmd_bl        <= '0;
         cmd_byte_addr <= '0;
      end else begin
         cmd_en <= 1'b0;
         done   <= 1'b0;
         if (state != IDLE && mcb_fault) begin
            error <= 1'b1;
         end
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_stb && req_ready) begin
                  req_ready <= 1'b0;
                  addr      <= {req_addr[29:2], 2'b00};
                  remaining <= req_count;
                  n         <= size_n;
                  beat      <= '0;
                  error     <= 1'b0;
                  if (req_count == '0) begin
                     state <= DONE;
                  end else if (req_write) begin
                     state <= WR_FILL;
                  end else begin
                     state <= RD_CMD;
                  end
               end
            end
            WR_FILL: begin
               if (wr_en) begin
                  if (beat == n - 7'd1) begin
                     beat  <= '0;
                     state <= WR_CMD;
                  end else begin
                     beat <= beat + 7'd1;
                  end
               end
            end
            WR_CMD: begin
               if (cmd_go) begin
                  cmd_en        <= 1'b1;
                  cmd_instr     <= MCB_INSTR_WRITE;
                  cmd_bl        <= 6'(n - 7'd1);
                  cmd_byte_addr <= addr;
                  addr          <= size_next_addr;
                  remaining     <= size_next_rem;
                  n             <= burst_words(32'(size_next_rem), MAX_BURST);
                  state         <= (size_next_rem == '0) ? DONE : WR_FILL;
               end
            end
            RD_CMD: begin
               if (cmd_go) begin
                  cmd_en        <= 1'b1;
                  cmd_instr     <= MCB_INSTR_READ;
                  cmd_bl        <= 6'(n - 7'd1);
                  cmd_byte_addr <= addr;
                  state         <= RD_DRAIN;
               end
            end
            RD_DRAIN: begin
               if (rd_en) begin
                  if (beat == n - 7'd1) begin
                     beat      <= '0;
                     addr      <= size_next_addr;
                     remaining <= size_next_rem;
                     n         <= burst_words(32'(size_next_rem), MAX_BURST);
                     state     <= (size_next_rem == '0) ? DONE : RD_CMD;
                  end else begin
                     beat <= beat + 7'd1;
                  end
               end
            end
            DONE: begin
               done      <= 1'b1;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ARTEMIS_MCB_PORT_PERF_EN
   logic [31:0] cyc_count;
   logic [32:0] cyc_total;

   // The accept cycle counts as 1; the DONE cycle and the done pulse cycle are added at the end.
   assign cyc_total = {1'b0, cyc_count} + 33'd2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_count   <= '0;
         perf_cycles <= '0;
         perf_stall  <= '0;
      end else begin
         if (state == IDLE) begin
            if (req_stb && req_ready) begin
               cyc_count <= 32'd1;
            end
         end else if (cyc_count != '1) begin
            cyc_count <= cyc_count + 32'd1;
         end
         if (state == DONE) begin
            perf_cycles <= cyc_total[32] ? '1 : cyc_total[31:0];
         end
         if ((state == WR_CMD || state == RD_CMD) && !cmd_go && perf_stall != '1) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule
